// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: programmable divider with a glitch-free divisor handoff at period boundaries.
// Defining CLK_DIV_CTRL_BURST_EN adds start/burst_len/done so the counter runs bursts of N periods.
module clk_div_ctrl #(
  parameter int CNT_W   = 16,
  parameter int DEF_DIV = 40
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             sc,
  output logic             tick,
  output logic [CNT_W-1:0] cur_div
`ifdef CLK_DIV_CTRL_BURST_EN
  ,
  input  logic             start,
  input  logic [15:0]      burst_len,
  output logic             done
`endif
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);
  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_DIV);
  typedef enum logic {RUN, PEND} cfg_state_t;
  cfg_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, div_nxt, pend, pend_nxt;
  logic sc_nxt, active, accept;
`ifdef CLK_DIV_CTRL_BURST_EN
  typedef enum logic {IDLE, ACTIVE} burst_state_t;
  burst_state_t bstate, bstate_nxt;
  logic [15:0] rem, rem_nxt;
  logic done_nxt;
  assign active = bstate == ACTIVE;
  always_comb begin
    bstate_nxt = bstate;
    rem_nxt    = rem;
    done_nxt   = 1'b0;
    if (bstate == IDLE) begin
      if (start) begin
        done_nxt   = burst_len == 16'd0;
        bstate_nxt = burst_len == 16'd0 ? IDLE : ACTIVE;
        rem_nxt    = burst_len;
      end
    end else if (tick) begin
      rem_nxt    = rem - 16'd1;
      done_nxt   = rem == 16'd1;
      bstate_nxt = rem == 16'd1 ? IDLE : ACTIVE;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      bstate <= IDLE;
      rem    <= '0;
      done   <= 1'b0;
    end else begin
      bstate <= bstate_nxt;
      rem    <= rem_nxt;
      done   <= done_nxt;
    end
  end
`else
  assign active = 1'b1;
`endif
  assign cfg_ready = state == RUN;
  assign accept    = cfg_ready && cfg_valid;
  assign tick      = en && active && cnt == cur_div - ONE;
  // A tick that coincides with an accept still wraps on the old divisor; the swap waits for PEND.
  always_comb begin
    pend_nxt  = accept ? (cfg_div < TWO ? TWO : cfg_div) : pend;
    div_nxt   = tick && state == PEND ? pend : cur_div;
    cnt_nxt   = tick ? '0 : (en && active ? cnt + ONE : cnt);
    state_nxt = state == RUN ? (accept ? PEND : RUN) : (tick ? RUN : PEND);
    sc_nxt    = cnt_nxt >= (div_nxt >> 1);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= RUN;
      cnt     <= '0;
      cur_div <= DEF;
      pend    <= DEF;
      sc      <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      cur_div <= div_nxt;
      pend    <= pend_nxt;
      sc      <= sc_nxt;
    end
  end
endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed checks of clk_div_ctrl with DEF_DIV=4; burst checks when CLK_DIV_CTRL_BURST_EN is set.
module tb_clk_div_ctrl;
  logic clk = 1'b0, reset = 1'b0, en = 1'b0, cfg_valid = 1'b0;
  logic [15:0] cfg_div = '0;
  logic cfg_ready, sc, tick;
  logic [15:0] cur_div;
  int n_cmp = 0, n_err = 0;
`ifdef CLK_DIV_CTRL_BURST_EN
  logic start = 1'b0, done;
  logic [15:0] burst_len = '0;
`endif
  clk_div_ctrl #(.CNT_W(16), .DEF_DIV(4)) dut (
    .clk(clk), .reset(reset), .en(en), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .sc(sc), .tick(tick), .cur_div(cur_div)
`ifdef CLK_DIV_CTRL_BURST_EN
    , .start(start), .burst_len(burst_len), .done(done)
`endif
  );
  always #5 clk = ~clk;
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic run_period(input string tag, input int div, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_sc"}, {31'd0, sc}, {31'd0, (i % div) >= div / 2});
      chk({tag, "_tick"}, {31'd0, tick}, {31'd0, (i % div) == div - 1});
      cyc(1);
    end
  endtask
  initial begin
    cyc(3);
    chk("rst_sc", {31'd0, sc}, 0);
    chk("rst_tick", {31'd0, tick}, 0);
    chk("rst_div", {16'd0, cur_div}, 4);
    chk("rst_ready", {31'd0, cfg_ready}, 1);
    reset = 1'b1;
    en = 1'b1;
`ifdef CLK_DIV_CTRL_BURST_EN
    cyc(2);
    chk("idle_sc", {31'd0, sc}, 0);
    chk("idle_tick", {31'd0, tick}, 0);
    burst_len = 16'd3;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("burst_tick", {31'd0, tick}, {31'd0, (i % 4) == 3});
      chk("burst_done_lo", {31'd0, done}, 0);
      cyc(1);
    end
    chk("burst_done", {31'd0, done}, 1);
    chk("burst_end_sc", {31'd0, sc}, 0);
    chk("burst_end_tick", {31'd0, tick}, 0);
    cyc(1);
    chk("burst_done_clr", {31'd0, done}, 0);
    for (int i = 0; i < 4; i++) begin
      chk("post_tick", {31'd0, tick}, 0);
      chk("post_sc", {31'd0, sc}, 0);
      cyc(1);
    end
    burst_len = 16'd0;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("zero_done", {31'd0, done}, 1);
    chk("zero_tick", {31'd0, tick}, 0);
    cyc(1);
    chk("zero_done_clr", {31'd0, done}, 0);
    chk("zero_tick2", {31'd0, tick}, 0);
`else
    run_period("p4", 4, 8);
    cyc(1);
    cfg_valid = 1'b1;
    cfg_div = 16'd6;
    chk("acc_ready", {31'd0, cfg_ready}, 1);
    cyc(1);
    cfg_valid = 1'b0;
    chk("pend_ready", {31'd0, cfg_ready}, 0);
    chk("pend_div", {16'd0, cur_div}, 4);
    chk("pend_sc", {31'd0, sc}, 1);
    cyc(1);
    chk("old_tick", {31'd0, tick}, 1);
    cyc(1);
    chk("sw6_div", {16'd0, cur_div}, 6);
    chk("sw6_ready", {31'd0, cfg_ready}, 1);
    run_period("p6", 6, 12);
    cfg_valid = 1'b1;
    cfg_div = 16'd1;
    cyc(1);
    cfg_valid = 1'b0;
    cyc(4);
    chk("p6_last_tick", {31'd0, tick}, 1);
    cyc(1);
    chk("clamp1_div", {16'd0, cur_div}, 2);
    run_period("p2", 2, 6);
    cfg_valid = 1'b1;
    cfg_div = 16'd5;
    cyc(1);
    cfg_valid = 1'b0;
    cyc(1);
    chk("sw5_div", {16'd0, cur_div}, 5);
    run_period("p5", 5, 10);
    cyc(2);
    en = 1'b0;
    chk("frz_tick0", {31'd0, tick}, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("frz_sc", {31'd0, sc}, 1);
      chk("frz_tick", {31'd0, tick}, 0);
    end
    en = 1'b1;
    cyc(1);
    chk("thaw_cnt3_tick", {31'd0, tick}, 0);
    cyc(1);
    chk("thaw_tick", {31'd0, tick}, 1);
    cyc(1);
    chk("thaw_wrap_sc", {31'd0, sc}, 0);
    cyc(4);
    cfg_valid = 1'b1;
    cfg_div = 16'd3;
    chk("coin_tick", {31'd0, tick}, 1);
    cyc(1);
    cfg_valid = 1'b0;
    chk("coin_div", {16'd0, cur_div}, 5);
    chk("coin_ready", {31'd0, cfg_ready}, 0);
    run_period("coin_p5", 5, 5);
    chk("sw3_div", {16'd0, cur_div}, 3);
    chk("sw3_ready", {31'd0, cfg_ready}, 1);
    run_period("p3", 3, 6);
    cfg_valid = 1'b1;
    cfg_div = 16'd6;
    cyc(1);
    cfg_valid = 1'b0;
    chk("pre_rst_ready", {31'd0, cfg_ready}, 0);
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    chk("rst2_div", {16'd0, cur_div}, 4);
    chk("rst2_ready", {31'd0, cfg_ready}, 1);
    chk("rst2_sc", {31'd0, sc}, 0);
    run_period("rst2_p4", 4, 8);
    chk("rst2_div_kept", {16'd0, cur_div}, 4);
    cfg_valid = 1'b1;
    cfg_div = 16'd0;
    cyc(1);
    cfg_valid = 1'b0;
    cyc(3);
    chk("clamp0_div", {16'd0, cur_div}, 2);
    run_period("clamp0_p2", 2, 4);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
